// File: rtl/seanetnackgenerator_timer_arbcore.sv
// seanetnackgenerator_timer_arbcore: round-robin new-timer / bounded-priority reload arbiter with deadline stamping.
// Optional exponential backoff of the timeout is enabled by defining SEANET_TMG_BACKOFF_EN.
module seanetnackgenerator_timer_arbcore #(
    parameter int NUM_CH      = 4,
    parameter int SN_WIDTH    = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int CHK_WIDTH   = 32,
    parameter int REQ_WIDTH   = 448,
    parameter int TS_WIDTH    = 32,
    parameter int MAX_RELOAD  = 8,
    parameter int STARVE_LIM  = 4,
    parameter int BACKOFF_MAX = 5,
    localparam int TIMER_WIDTH = TS_WIDTH + CNT_WIDTH + SN_WIDTH + CHK_WIDTH + REQ_WIDTH
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_CH*SN_WIDTH-1:0]    i_new_sn,
    input  logic [NUM_CH*CHK_WIDTH-1:0]   i_new_chksum,
    input  logic [NUM_CH*REQ_WIDTH-1:0]   i_new_gen_req,
    input  logic [NUM_CH-1:0]             i_new_valid,
    output logic [NUM_CH-1:0]             o_new_ready,
    input  logic [SN_WIDTH-1:0]           i_rld_sn,
    input  logic [CNT_WIDTH-1:0]          i_rld_cnt,
    input  logic [CHK_WIDTH-1:0]          i_rld_chksum,
    input  logic [REQ_WIDTH-1:0]          i_rld_gen_req,
    input  logic                          i_rld_valid,
    output logic                          o_rld_ready,
    input  logic [TS_WIDTH-1:0]           i_now,
    input  logic [TS_WIDTH-1:0]           i_cfg_timeout,
    input  logic                          i_cfg_clr,
    output logic [TIMER_WIDTH-1:0]        o_timer_wrreq,
    output logic                          o_timer_wrreq_vld,
    input  logic                          i_timer_wrreq_rdy,
    output logic [SN_WIDTH-1:0]           o_expire_sn,
    output logic                          o_expire_vld,
    output logic [31:0]                   o_sta_reg0,
    output logic [31:0]                   o_sta_reg1,
    output logic [31:0]                   o_sta_reg2,
    output logic [31:0]                   o_sta_reg3
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
`ifdef SEANET_TMG_BACKOFF_EN
    localparam bit BO_EN = 1'b1;
`else
    localparam bit BO_EN = 1'b0;
`endif

    logic                   slot_free, any_new, rld_exp, rld_norm, rld_gnt, new_gnt, new_hit;
    logic [PW-1:0]          new_idx, rr_q, rr_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   vld_q, vld_d, xv_q, xv_d;
    logic [TIMER_WIDTH-1:0] ent_q, ent_d;
    logic [SN_WIDTH-1:0]    xsn_q, xsn_d, e_sn;
    logic [CNT_WIDTH-1:0]   e_cnt, shamt;
    logic [CHK_WIDTH-1:0]   e_chk;
    logic [REQ_WIDTH-1:0]   e_req;
    logic [TS_WIDTH-1:0]    timeout, deadline;
    logic [3:0]             sta_inc;
    logic [3:0][31:0]       sta_q, sta_d;
    int                     idx;

    assign slot_free = !vld_q || i_timer_wrreq_rdy;
    assign any_new   = |i_new_valid;
    assign rld_exp   = i_rld_valid && (i_rld_cnt >= CNT_WIDTH'(MAX_RELOAD));
    assign rld_norm  = i_rld_valid && !rld_exp;
    assign rld_gnt   = rld_norm && slot_free && (!any_new || starve_q < SW'(STARVE_LIM));
    assign new_gnt   = slot_free && !rld_gnt && new_hit;

    // Scan downward so the lowest offset from rr_q wins the last assignment.
    always_comb begin
        new_hit = 1'b0;
        new_idx = '0;
        idx     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (i_new_valid[idx]) begin
                new_hit = 1'b1;
                new_idx = PW'(idx);
            end
        end
    end

    assign o_new_ready = new_gnt ? (NUM_CH'(1) << new_idx) : '0;
    assign o_rld_ready = rld_exp || rld_gnt;

    always_comb begin
        e_sn     = rld_gnt ? i_rld_sn      : i_new_sn[new_idx*SN_WIDTH +: SN_WIDTH];
        e_chk    = rld_gnt ? i_rld_chksum  : i_new_chksum[new_idx*CHK_WIDTH +: CHK_WIDTH];
        e_req    = rld_gnt ? i_rld_gen_req : i_new_gen_req[new_idx*REQ_WIDTH +: REQ_WIDTH];
        e_cnt    = rld_gnt ? i_rld_cnt + CNT_WIDTH'(1) : '0;
        shamt    = (e_cnt > CNT_WIDTH'(BACKOFF_MAX)) ? CNT_WIDTH'(BACKOFF_MAX) : e_cnt;
        timeout  = BO_EN ? (i_cfg_timeout << shamt) : i_cfg_timeout;
        deadline = i_now + timeout;
        ent_d    = (rld_gnt || new_gnt) ? {deadline, e_cnt, e_sn, e_chk, e_req} : ent_q;
        vld_d    = slot_free ? (rld_gnt || new_gnt) : vld_q;
        xv_d     = rld_exp;
        xsn_d    = rld_exp ? i_rld_sn : xsn_q;
        rr_d     = new_gnt ? ((new_idx == PW'(NUM_CH - 1)) ? '0 : new_idx + PW'(1)) : rr_q;
        starve_d = (new_gnt || !any_new) ? '0 : (rld_gnt ? starve_q + SW'(1) : starve_q);
    end

    // Saturating status counters; clear takes priority over increment.
    assign sta_inc = {vld_q && !i_timer_wrreq_rdy, rld_exp, rld_gnt, new_gnt};

    always_comb begin
        sta_d = sta_q;
        for (int i = 0; i < 4; i++)
            sta_d[i] = i_cfg_clr ? '0 : ((sta_inc[i] && sta_q[i] != '1) ? sta_q[i] + 32'd1 : sta_q[i]);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_q    <= 1'b0;
            ent_q    <= '0;
            xv_q     <= 1'b0;
            xsn_q    <= '0;
            rr_q     <= '0;
            starve_q <= '0;
            sta_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            ent_q    <= ent_d;
            xv_q     <= xv_d;
            xsn_q    <= xsn_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            sta_q    <= sta_d;
        end
    end

    assign o_timer_wrreq     = ent_q;
    assign o_timer_wrreq_vld = vld_q;
    assign o_expire_vld      = xv_q;
    assign o_expire_sn       = xsn_q;
    assign o_sta_reg0        = sta_q[0];
    assign o_sta_reg1        = sta_q[1];
    assign o_sta_reg2        = sta_q[2];
    assign o_sta_reg3        = sta_q[3];

endmodule

// File: tb/tb_seanetnackgenerator_timer_arbcore.sv
// tb_seanetnackgenerator_timer_arbcore: table-driven vectors plus hand sequences for stall, clear and reset.
module tb_seanetnackgenerator_timer_arbcore;
    logic           sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic [63:0]    i_new_sn;
    logic [127:0]   i_new_chksum;
    logic [1791:0]  i_new_gen_req;
    logic [3:0]     i_new_valid = '0, o_new_ready;
    logic [15:0]    i_rld_sn = '0, i_rld_cnt = '0, o_expire_sn;
    logic [31:0]    i_rld_chksum = 32'hC0DE;
    logic [447:0]   i_rld_gen_req = 448'h5A5A;
    logic           i_rld_valid = 1'b0, o_rld_ready;
    logic [31:0]    i_now = 32'd1000, i_cfg_timeout = 32'd100;
    logic           i_cfg_clr = 1'b0;
    logic [543:0]   o_timer_wrreq;
    logic           o_timer_wrreq_vld, i_timer_wrreq_rdy = 1'b1, o_expire_vld;
    logic [31:0]    o_sta_reg0, o_sta_reg1, o_sta_reg2, o_sta_reg3;
    int             errors = 0, checks = 0;

    seanetnackgenerator_timer_arbcore dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_new_sn(i_new_sn), .i_new_chksum(i_new_chksum), .i_new_gen_req(i_new_gen_req),
        .i_new_valid(i_new_valid), .o_new_ready(o_new_ready),
        .i_rld_sn(i_rld_sn), .i_rld_cnt(i_rld_cnt), .i_rld_chksum(i_rld_chksum),
        .i_rld_gen_req(i_rld_gen_req), .i_rld_valid(i_rld_valid), .o_rld_ready(o_rld_ready),
        .i_now(i_now), .i_cfg_timeout(i_cfg_timeout), .i_cfg_clr(i_cfg_clr),
        .o_timer_wrreq(o_timer_wrreq), .o_timer_wrreq_vld(o_timer_wrreq_vld),
        .i_timer_wrreq_rdy(i_timer_wrreq_rdy), .o_expire_sn(o_expire_sn), .o_expire_vld(o_expire_vld),
        .o_sta_reg0(o_sta_reg0), .o_sta_reg1(o_sta_reg1), .o_sta_reg2(o_sta_reg2), .o_sta_reg3(o_sta_reg3)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  nv;
        logic        rv;
        logic [15:0] rcnt, rsn;
        logic [31:0] now;
        logic [3:0]  e_nr;
        logic        e_rr, e_vld;
        logic [15:0] e_sn, e_cnt;
        logic [31:0] e_dl;
        logic        e_xv;
        logic [15:0] e_xsn;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(logic [3:0] nv, logic rv, logic [15:0] rcnt, logic [15:0] rsn, logic [31:0] now,
                                logic [3:0] e_nr, logic e_rr, logic e_vld, logic [15:0] e_sn, logic [15:0] e_cnt,
                                logic [31:0] e_dl, logic e_xv, logic [15:0] e_xsn);
        vec_t v;
        v.nv = nv; v.rv = rv; v.rcnt = rcnt; v.rsn = rsn; v.now = now;
        v.e_nr = e_nr; v.e_rr = e_rr; v.e_vld = e_vld; v.e_sn = e_sn; v.e_cnt = e_cnt;
        v.e_dl = e_dl; v.e_xv = e_xv; v.e_xsn = e_xsn;
        return v;
    endfunction

    function automatic logic [31:0] dl(logic [31:0] now, logic [15:0] cnt);
`ifdef SEANET_TMG_BACKOFF_EN
        return now + (32'd100 << ((cnt > 16'd5) ? 16'd5 : cnt));
`else
        return now + 32'd100;
`endif
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_entry(string tag, logic [15:0] sn, logic [15:0] cnt, logic [31:0] dlv);
        logic [31:0] chk_exp;
        chk_exp = (sn[15:8] == 8'h01) ? 32'hA0 + 32'(sn[3:0]) : 32'hC0DE;
        chk({tag, ".vld"}, 64'(o_timer_wrreq_vld), 64'd1);
        chk({tag, ".sn"},  64'(o_timer_wrreq[495:480]), 64'(sn));
        chk({tag, ".cnt"}, 64'(o_timer_wrreq[511:496]), 64'(cnt));
        chk({tag, ".dl"},  64'(o_timer_wrreq[543:512]), 64'(dlv));
        chk({tag, ".chk"}, 64'(o_timer_wrreq[479:448]), 64'(chk_exp));
    endtask

    initial begin
        logic [31:0] s3;
        for (int k = 0; k < 4; k++) begin
            i_new_sn[k*16 +: 16]       = 16'h100 + 16'(k);
            i_new_chksum[k*32 +: 32]   = 32'hA0 + 32'(k);
            i_new_gen_req[k*448 +: 448] = 448'(k + 1);
        end
        // Vectors are applied in order; rr_ptr and starve state carry over between them.
        vt[0]  = mk(4'b1111, 0, 0, 0, 1000, 4'b0001, 0, 1, 16'h100, 0, dl(1000, 0), 0, 0);
        vt[1]  = mk(4'b1111, 0, 0, 0, 1000, 4'b0010, 0, 1, 16'h101, 0, dl(1000, 0), 0, 0);
        vt[2]  = mk(4'b1111, 0, 0, 0, 1000, 4'b0100, 0, 1, 16'h102, 0, dl(1000, 0), 0, 0);
        vt[3]  = mk(4'b1111, 0, 0, 0, 1000, 4'b1000, 0, 1, 16'h103, 0, dl(1000, 0), 0, 0);
        vt[4]  = mk(4'b1111, 0, 0, 0, 1000, 4'b0001, 0, 1, 16'h100, 0, dl(1000, 0), 0, 0);
        for (int i = 5; i < 9; i++)
            vt[i] = mk(4'b0100, 1, 1, 16'h55, 1000, 4'b0000, 1, 1, 16'h55, 2, dl(1000, 2), 0, 0);
        vt[9]  = mk(4'b0100, 1, 1, 16'h55, 1000, 4'b0100, 0, 1, 16'h102, 0, dl(1000, 0), 0, 0);
        vt[10] = mk(4'b0100, 1, 1, 16'h55, 1000, 4'b0000, 1, 1, 16'h55, 2, dl(1000, 2), 0, 0);
        vt[11] = mk(4'b0010, 1, 8, 16'h1234, 1000, 4'b0010, 1, 1, 16'h101, 0, dl(1000, 0), 1, 16'h1234);
        vt[12] = mk(4'b0000, 0, 0, 0, 1000, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
`ifdef SEANET_TMG_BACKOFF_EN
        vt[13] = mk(4'b0000, 1, 2, 16'h77, 32'hFFFF_FF00, 4'b0000, 1, 1, 16'h77, 3, 32'h0000_0220, 0, 0);
`else
        vt[13] = mk(4'b0000, 1, 2, 16'h77, 32'hFFFF_FF00, 4'b0000, 1, 1, 16'h77, 3, 32'hFFFF_FF64, 0, 0);
`endif
        vt[14] = mk(4'b0001, 0, 0, 0, 1000, 4'b0001, 0, 1, 16'h100, 0, dl(1000, 0), 0, 0);
        vt[15] = mk(4'b1001, 0, 0, 0, 1000, 4'b1000, 0, 1, 16'h103, 0, dl(1000, 0), 0, 0);

        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst.vld", 64'(o_timer_wrreq_vld), 0);
        chk("rst.entry_lo", o_timer_wrreq[63:0], 0);
        chk("rst.xv", 64'(o_expire_vld), 0);
        chk("rst.xsn", 64'(o_expire_sn), 0);
        chk("rst.sta", 64'(o_sta_reg0 | o_sta_reg1 | o_sta_reg2 | o_sta_reg3), 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            i_new_valid = vt[i].nv;
            i_rld_valid = vt[i].rv;
            i_rld_cnt   = vt[i].rcnt;
            i_rld_sn    = vt[i].rsn;
            i_now       = vt[i].now;
            #1;
            chk($sformatf("v%0d.new_ready", i), 64'(o_new_ready), 64'(vt[i].e_nr));
            chk($sformatf("v%0d.rld_ready", i), 64'(o_rld_ready), 64'(vt[i].e_rr));
            @(posedge sys_clk);
            #1;
            if (vt[i].e_vld) chk_entry($sformatf("v%0d", i), vt[i].e_sn, vt[i].e_cnt, vt[i].e_dl);
            else chk($sformatf("v%0d.vld", i), 64'(o_timer_wrreq_vld), 0);
            chk($sformatf("v%0d.xv", i), 64'(o_expire_vld), 64'(vt[i].e_xv));
            if (vt[i].e_xv) chk($sformatf("v%0d.xsn", i), 64'(o_expire_sn), 64'(vt[i].e_xsn));
        end
        chk("sta0", 64'(o_sta_reg0), 9);
        chk("sta1", 64'(o_sta_reg1), 6);
        chk("sta2", 64'(o_sta_reg2), 1);
        chk("sta3", 64'(o_sta_reg3), 0);

        // Backpressure: entry held, new readies dropped, stall counter +5.
        i_new_valid = 4'b1111;
        i_rld_valid = 1'b0;
        i_now = 1000;
        @(posedge sys_clk);
        #1;
        chk_entry("bp.first", 16'h100, 0, dl(1000, 0));
        s3 = o_sta_reg3;
        i_timer_wrreq_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d.new_ready", i), 64'(o_new_ready), 0);
            @(posedge sys_clk);
            #1;
            chk_entry($sformatf("bp%0d", i), 16'h100, 0, dl(1000, 0));
        end
        chk("bp.sta3", 64'(o_sta_reg3), 64'(s3 + 32'd5));
        i_timer_wrreq_rdy = 1'b1;
        #1;
        chk("bp.resume_ready", 64'(o_new_ready), 64'b0010);
        @(posedge sys_clk);
        #1;
        chk_entry("bp.resume", 16'h101, 0, dl(1000, 0));

        i_new_valid = '0;
        i_cfg_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        i_cfg_clr = 1'b0;
        chk("clr.sta", 64'(o_sta_reg0 | o_sta_reg1 | o_sta_reg2 | o_sta_reg3), 0);

        // Async reset with an entry held and an expire pulse pending.
        i_new_valid = 4'b0001;
        i_rld_valid = 1'b1;
        i_rld_cnt = 16'd9;
        i_rld_sn = 16'hBEEF;
        i_timer_wrreq_rdy = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("pre_rst.vld", 64'(o_timer_wrreq_vld), 1);
        chk("pre_rst.xv", 64'(o_expire_vld), 1);
        chk("pre_rst.xsn", 64'(o_expire_sn), 16'hBEEF);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst.vld", 64'(o_timer_wrreq_vld), 0);
        chk("async_rst.xv", 64'(o_expire_vld), 0);
        chk("async_rst.entry_hi", 64'(o_timer_wrreq[543:480]), 0);
        i_new_valid = 4'b1111;
        i_rld_valid = 1'b0;
        i_timer_wrreq_rdy = 1'b1;
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        #1;
        chk("post_rst.new_ready", 64'(o_new_ready), 64'b0001);
        @(posedge sys_clk);
        #1;
        chk_entry("post_rst", 16'h100, 0, dl(1000, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seanetnackgenerator_timer_arbcore.md
# seanetnackgenerator_timer_arbcore

Parametrised successor to the NACK-generator timer request path. It arbitrates NUM_CH independent new-timer request channels against one reload channel from the alarm comparator, applying round-robin among the new channels and bounded-priority for reloads. It retires reloads that exceed the retry limit and stamps each entry with an absolute deadline, optionally with exponential backoff. Entries go through a registered output stage to the timer queue manager.

## Interface
- NUM_CH, 4: number of new-timer request channels (1..16)
- SN_WIDTH, 16: stream number width
- CNT_WIDTH, 16: reload count width
- CHK_WIDTH, 32: checksum width
- REQ_WIDTH, 448: generation request width
- TS_WIDTH, 32: timestamp/deadline width
- MAX_RELOAD, 8: reload count at which a timer expires instead of reloading
- STARVE_LIM, 4: consecutive reload grants allowed while any new channel is pending
- BACKOFF_MAX, 5: maximum backoff shift
- localparam TIMER_WIDTH = TS_WIDTH+CNT_WIDTH+SN_WIDTH+CHK_WIDTH+REQ_WIDTH (544)

Ports (clock and reset first):
- sys_clk  in  1  sole clock
- sys_rst_n  in  1  asynchronous, active-low reset
- i_new_sn  in  NUM_CH*SN_WIDTH  per-channel SN, channel k at slice k
- i_new_chksum  in  NUM_CH*CHK_WIDTH  per-channel checksum
- i_new_gen_req  in  NUM_CH*REQ_WIDTH  per-channel generation request
- i_new_valid  in  NUM_CH  per-channel valid
- o_new_ready  out  NUM_CH  per-channel ready (one-hot or zero)
- i_rld_sn / i_rld_cnt / i_rld_chksum / i_rld_gen_req  in  SN/CNT/CHK/REQ_WIDTH  reload request
- i_rld_valid  in 1, o_rld_ready  out 1  reload handshake
- i_now  in  TS_WIDTH  free-running time
- i_cfg_timeout  in  TS_WIDTH  base timeout
- i_cfg_clr  in  1  clear status counters
- o_timer_wrreq  out  TIMER_WIDTH  entry, LSB-first {gen_req, chksum, sn, cnt, deadline}
- o_timer_wrreq_vld  out 1, i_timer_wrreq_rdy  in 1  output handshake
- o_expire_sn  out  SN_WIDTH; o_expire_vld  out 1  retired-timer report
- o_sta_reg0..3  out  32 each: new accepted, reload accepted, expired, output stall cycles

## Operation
- Output stage is one register. slot_free = !o_timer_wrreq_vld || i_timer_wrreq_rdy.
- Expire: i_rld_valid && i_rld_cnt >= MAX_RELOAD. o_rld_ready=1 unconditionally, no slot used. The next cycle gives o_expire_vld=1 for one cycle with o_expire_sn=i_rld_sn.
- Normal reload: i_rld_valid && cnt < MAX_RELOAD. It is granted when slot_free and (no new valid, or starve_cnt < STARVE_LIM).
- New grant: when slot_free and the reload is not granted, the first valid channel searching from rr_ptr upward, with wrap, is granted. rr_ptr then becomes grant+1 mod NUM_CH.
- starve_cnt increments on a reload grant while any i_new_valid is set. It clears on any new grant or when no new valid is pending.
- An expire and a new grant can occur in the same cycle.
- Entry fields: new entry cnt = 0; reload entry cnt = i_rld_cnt+1.
- deadline = (i_now + timeout) mod 2^TS_WIDTH. timeout is defined under Configuration.
- Status counters saturate at 2^32-1 and clear on i_cfg_clr. The stall counter counts cycles with vld && !rdy.

## Timing
- Reset values: o_timer_wrreq_vld=0, o_timer_wrreq=0, o_expire_vld=0, o_expire_sn=0, all o_sta_reg=0, rr_ptr=0, starve_cnt=0.
- Latency: accept at cycle N gives o_timer_wrreq_vld at N+1. Full throughput is one entry per cycle when rdy is held high.
- Readies are combinational from valids and slot_free. A held output (vld && !rdy) keeps data stable and deasserts every non-expire ready.
- Reset assertion mid-transfer drops the held entry and any pending expire pulse immediately.

## Configuration
- SEANET_TMG_BACKOFF_EN defined: timeout = i_cfg_timeout << min(cnt, BACKOFF_MAX), truncated to TS_WIDTH.
- Not defined: timeout = i_cfg_timeout for every entry.

## Test plan
- Round-robin: all 4 channels valid, rdy=1 → grants in order ch0,1,2,3,0, with vld every cycle from cycle 1. Each entry has cnt=0 and deadline = i_now+100 when i_cfg_timeout=100.
- Reload starvation: reload plus ch2 valid continuously, STARVE_LIM=4 → four reload grants, then one ch2 grant, repeating.
- Expire: reload with cnt=8, SN 0x1234, while ch1 is valid → o_rld_ready and o_new_ready[1] both high in the same cycle. Next cycle gives o_expire_vld=1 with SN 0x1234, and the entry carries ch1.
- Backoff (macro on): reload cnt=2, timeout=100, now=0xFFFF_FF00 → entry cnt=3, deadline=0x0000_0220. With the macro off, deadline=0xFFFF_FF64.
- Backpressure: rdy=0 for 5 cycles with vld=1 → entry held stable, all new readies 0, o_sta_reg3 increments by 5.
- Reset: assert sys_rst_n=0 asynchronously while vld=1 → o_timer_wrreq_vld=0 at once, and the first post-reset grant goes to ch0.
